// File: rtl/sio_pkg.sv
// Shared types and constants for the serial remote-IO host transaction scheduler.
package sio_pkg;

  localparam int SIO_ADDR_W   = 8;
  localparam int SIO_DATA_W   = 32;
  localparam int SIO_WORD_W   = SIO_ADDR_W + SIO_DATA_W;
  localparam int SIO_SLOT_MIN = 26;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } sio_state_e;

  function automatic logic [SIO_WORD_W-1:0] sio_word(input logic [SIO_ADDR_W-1:0] addr,
                                                     input logic [SIO_DATA_W-1:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/sio_rr_arb.sv
// Combinational round-robin arbiter; search starts one past the last granted requester.
module sio_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  int   k;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last_grant) + i) % NREQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/sio_host_sched.sv
// Round-robin transaction scheduler sharing one sio_host between NREQ requesters.
// Optional periodic status poll enabled by defining SIO_SCHED_POLL_EN.
//
// state | meaning
// IDLE  | no transaction; arbitrate requests / pending poll
// ISSUE | sio_wvalid pulse with the latched {addr,data}
// WAIT  | count out the link slot, capture sio_rdata at terminal count
// RESP  | ack / poll_valid pulse is visible
// GAP   | link turnaround; on the last cycle a new winner may launch directly
module sio_host_sched
  import sio_pkg::*;
#(
  parameter int                    NREQ          = 4,
  parameter int                    SLOT          = 32,
  parameter int                    GAP           = 2,
  parameter logic [SIO_ADDR_W-1:0] POLL_ADDR     = 8'h00,
  parameter int                    POLL_INTERVAL = 1024
) (
  input  logic                       c,
  input  logic                       r,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*SIO_ADDR_W-1:0] req_addr,
  input  logic [NREQ*SIO_DATA_W-1:0] req_data,
  output logic [NREQ-1:0]            ack,
  output logic [SIO_DATA_W-1:0]      rsp_data,
  output logic                       busy,
  output logic                       sio_wvalid,
  output logic [SIO_WORD_W-1:0]      sio_wdata,
  input  logic [SIO_DATA_W-1:0]      sio_rdata
`ifdef SIO_SCHED_POLL_EN
  ,
  output logic                       poll_valid,
  output logic [SIO_DATA_W-1:0]      poll_data
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(((SLOT > GAP) ? SLOT : GAP) + 1);

  if (SLOT < SIO_SLOT_MIN) begin : g_bad_slot
    $error("sio_host_sched: SLOT too short for the host round trip");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("sio_host_sched: GAP must be at least 1");
  end

  sio_state_e      state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last_grant;
  logic [NREQ-1:0] cur_grant;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            launch_ok;
  logic            launch;
  logic            poll_pend;

  sio_rr_arb #(.NREQ(NREQ)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Last GAP cycle doubles as an arbitration slot so back-to-back spacing is SLOT+GAP+2.
  assign launch_ok = (state == ST_IDLE) || ((state == ST_GAP) && (cnt == '0));
  assign launch    = launch_ok && (poll_pend || (|req));
  assign busy      = (state != ST_IDLE);

`ifdef SIO_SCHED_POLL_EN
  localparam int PW = $clog2(POLL_INTERVAL);

  logic [PW-1:0] poll_tmr;
  logic          cur_poll;

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      poll_tmr  <= PW'(POLL_INTERVAL - 1);
      poll_pend <= 1'b0;
    end else begin
      if (launch && poll_pend)
        poll_pend <= 1'b0;
      // An expiry while a poll is still pending merges into it.
      if (poll_tmr == '0) begin
        poll_tmr  <= PW'(POLL_INTERVAL - 1);
        poll_pend <= 1'b1;
      end else begin
        poll_tmr <= poll_tmr - 1'b1;
      end
    end
  end
`else
  assign poll_pend = 1'b0;
`endif

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= IW'(NREQ - 1);
      cur_grant  <= '0;
      ack        <= '0;
      rsp_data   <= '0;
      sio_wvalid <= 1'b0;
      sio_wdata  <= '0;
`ifdef SIO_SCHED_POLL_EN
      cur_poll   <= 1'b0;
      poll_valid <= 1'b0;
      poll_data  <= '0;
`endif
    end else begin
      sio_wvalid <= 1'b0;
      sio_wdata  <= '0;
      ack        <= '0;
`ifdef SIO_SCHED_POLL_EN
      poll_valid <= 1'b0;
`endif
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_ISSUE: begin
          cnt   <= CW'(SLOT - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
`ifdef SIO_SCHED_POLL_EN
            if (cur_poll) begin
              poll_valid <= 1'b1;
              poll_data  <= sio_rdata;
            end else begin
              ack      <= cur_grant;
              rsp_data <= sio_rdata;
            end
`else
            ack      <= cur_grant;
            rsp_data <= sio_rdata;
`endif
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          cnt   <= CW'(GAP - 1);
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      if (launch) begin
        state      <= ST_ISSUE;
        sio_wvalid <= 1'b1;
        if (poll_pend) begin
          sio_wdata <= sio_word(POLL_ADDR, '0);
`ifdef SIO_SCHED_POLL_EN
          cur_poll  <= 1'b1;
`endif
        end else begin
          sio_wdata  <= sio_word(req_addr[SIO_ADDR_W*int'(grant_idx) +: SIO_ADDR_W],
                                 req_data[SIO_DATA_W*int'(grant_idx) +: SIO_DATA_W]);
          cur_grant  <= grant;
          last_grant <= grant_idx;
`ifdef SIO_SCHED_POLL_EN
          cur_poll   <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sio_host_sched.sv
// Directed self-checking bench for sio_host_sched (SLOT=32, GAP=2, NREQ=4).
// With SIO_SCHED_POLL_EN defined, runs the poll-collision scenario instead of the requester tests.
module tb_sio_host_sched;

  logic         c = 1'b0;
  logic         r = 1'b0;
  logic [3:0]   req = '0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   ack;
  logic [31:0]  rsp_data;
  logic         busy;
  logic         sio_wvalid;
  logic [39:0]  sio_wdata;
  logic [31:0]  sio_rdata = '0;
`ifdef SIO_SCHED_POLL_EN
  logic         poll_valid;
  logic [31:0]  poll_data;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  int wq[$];
  int gq[$];
  int aq[$];
  int n_consec = 0;
  int n_multi  = 0;
  int ack_cnt[4];
  logic prev_wv = 1'b0;

  sio_host_sched #(
    .NREQ(4), .SLOT(32), .GAP(2), .POLL_ADDR(8'h00), .POLL_INTERVAL(128)
  ) dut (
    .c(c), .r(r), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .rsp_data(rsp_data), .busy(busy),
    .sio_wvalid(sio_wvalid), .sio_wdata(sio_wdata), .sio_rdata(sio_rdata)
`ifdef SIO_SCHED_POLL_EN
    , .poll_valid(poll_valid), .poll_data(poll_data)
`endif
  );

  always #5 c = ~c;
  always @(posedge c) cyc++;

  always @(negedge c) begin
    if (r) begin
      if (sio_wvalid) begin
        wq.push_back(cyc);
        if (prev_wv) n_consec++;
      end
      prev_wv = sio_wvalid;
      if (ack != 4'b0) begin
        if ($countones(ack) != 1) n_multi++;
        for (int i = 0; i < 4; i++)
          if (ack[i]) begin
            gq.push_back(i);
            aq.push_back(cyc);
            ack_cnt[i]++;
          end
      end
    end else begin
      prev_wv = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge c);
    #1;
  endtask

  task automatic clear_mon();
    wq.delete();
    gq.delete();
    aq.delete();
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] d);
    req_addr[8*i +: 8]   = a;
    req_data[32*i +: 32] = d;
  endtask

  task automatic wait_wvalid(input string tag, input int budget);
    int n;
    n = 0;
    while (!sio_wvalid && n < budget) begin step(); n++; end
    check(tag, {63'b0, sio_wvalid}, 64'd1);
  endtask

  task automatic wait_ack(input string tag, input int idx, input int budget);
    int n;
    n = 0;
    while (!ack[idx] && n < budget) begin step(); n++; end
    check(tag, {63'b0, ack[idx]}, 64'd1);
  endtask

  task automatic wait_gq(input string tag, input int cnt, input int budget);
    int n;
    n = 0;
    while (gq.size() < cnt && n < budget) begin step(); n++; end
    check(tag, 64'(gq.size()), 64'(cnt));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin step(); n++; end
    check(tag, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    int t0;
    int early;
    int rep;

    r = 1'b0;
    repeat (3) step();
    check("rst_ack",   64'(ack), 64'd0);
    check("rst_busy",  {63'b0, busy}, 64'd0);
    check("rst_wv",    {63'b0, sio_wvalid}, 64'd0);
    check("rst_wdata", 64'(sio_wdata), 64'd0);
    check("rst_rsp",   64'(rsp_data), 64'd0);
`ifdef SIO_SCHED_POLL_EN
    check("rst_pv",    {63'b0, poll_valid}, 64'd0);
    r = 1'b1;
    clear_mon();
    repeat (100) step();
    set_req(1, 8'h21, 32'h11111111);
    set_req(0, 8'h30, 32'h22222222);
    sio_rdata = 32'hCAFE0001;
    req = 4'b0010;
    step();
    check("poll_r1_wv",    {63'b0, sio_wvalid}, 64'd1);
    check("poll_r1_wdata", 64'(sio_wdata), 64'h21_11111111);
    repeat (10) step();
    req = 4'b0011;
    wait_ack("poll_r1_ack", 1, 40);
    req = 4'b0001;
    sio_rdata = 32'h5A5A1234;
    wait_wvalid("poll_issue_to", 10);
    check("poll_wdata", 64'(sio_wdata), 64'h00_00000000);
    repeat (33) step();
    check("poll_valid", {63'b0, poll_valid}, 64'd1);
    check("poll_data",  64'(poll_data), 64'h5A5A1234);
    check("poll_noack", 64'(ack), 64'd0);
    sio_rdata = 32'h77778888;
    wait_wvalid("poll_r0_to", 10);
    check("poll_r0_wdata", 64'(sio_wdata), 64'h30_22222222);
    wait_ack("poll_r0_ack", 0, 40);
    check("poll_r0_rsp", 64'(rsp_data), 64'h77778888);
    req = 4'b0000;
    wait_idle("poll_idle", 10);
    check("poll_consec", 64'(n_consec), 64'd0);
`else
    r = 1'b1;
    repeat (2) step();

    // Single request
    clear_mon();
    set_req(0, 8'h12, 32'hDEADBEEF);
    sio_rdata = 32'hCAFEF00D;
    req = 4'b0001;
    step();
    check("t1_wv",    {63'b0, sio_wvalid}, 64'd1);
    check("t1_wdata", 64'(sio_wdata), 64'h12_DEADBEEF);
    check("t1_busy",  {63'b0, busy}, 64'd1);
    early = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (ack != 4'b0) early++;
    end
    check("t1_early", 64'(early), 64'd0);
    step();
    check("t1_ack", 64'(ack), 64'b0001);
    check("t1_rsp", 64'(rsp_data), 64'hCAFEF00D);
    req = 4'b0000;
    step();
    check("t1_ack_pulse", 64'(ack), 64'd0);
    wait_idle("t1_idle", 10);

    // Simultaneous requests 1 and 3
    repeat (2) step();
    clear_mon();
    set_req(1, 8'h41, 32'h00000001);
    set_req(3, 8'h43, 32'h00000003);
    sio_rdata = 32'h0000ABCD;
    t0 = cyc;
    req = 4'b1010;
    wait_gq("t2_acks", 4, 4 * 36 + 20);
    req = 4'b0000;
    wait_idle("t2_idle", 10);
    check("t2_lat",  64'(wq[0] - t0), 64'd1);
    check("t2_g0",   64'(gq[0]), 64'd1);
    check("t2_g1",   64'(gq[1]), 64'd3);
    check("t2_g2",   64'(gq[2]), 64'd1);
    check("t2_g3",   64'(gq[3]), 64'd3);
    check("t2_sp01", 64'(wq[1] - wq[0]), 64'd36);
    check("t2_sp12", 64'(wq[2] - wq[1]), 64'd36);
    check("t2_sp23", 64'(wq[3] - wq[2]), 64'd36);
    check("t2_resp", 64'(aq[0] - wq[0]), 64'd33);
    check("t2_nwv",  64'(wq.size()), 64'd4);

    // Fairness with all four held
    repeat (2) step();
    clear_mon();
    set_req(0, 8'h50, 32'h0);
    set_req(2, 8'h52, 32'h2);
    req = 4'b1111;
    wait_gq("t3_acks", 40, 40 * 36 + 40);
    req = 4'b0000;
    wait_idle("t3_idle", 10);
    for (int i = 0; i < 4; i++) check($sformatf("t3_cnt%0d", i), 64'(ack_cnt[i]), 64'd10);
    rep = 0;
    for (int i = 1; i < 40; i++) if (gq[i] == gq[i-1]) rep++;
    check("t3_repeat", 64'(rep), 64'd0);
    check("t3_first",  64'(gq[0]), 64'd0);
    check("t3_multi",  64'(n_multi), 64'd0);

    // Withdrawn request
    repeat (2) step();
    clear_mon();
    set_req(0, 8'h60, 32'h60606060);
    set_req(2, 8'h62, 32'h62626262);
    sio_rdata = 32'h13572468;
    req = 4'b0001;
    step();
    check("t4_wv", {63'b0, sio_wvalid}, 64'd1);
    repeat (5) step();
    req = 4'b0101;
    repeat (3) step();
    req = 4'b0001;
    wait_ack("t4_ack0", 0, 40);
    req = 4'b0000;
    wait_idle("t4_idle", 10);
    repeat (4) step();
    check("t4_noack2", 64'(ack_cnt[2]), 64'd0);
    check("t4_nwv",    64'(wq.size()), 64'd1);
    check("t4_rsp",    64'(rsp_data), 64'h13572468);

    // Reset in the middle of the slot
    clear_mon();
    set_req(0, 8'h5A, 32'h0BADCAFE);
    sio_rdata = 32'h12345678;
    req = 4'b0001;
    step();
    check("t5_wv", {63'b0, sio_wvalid}, 64'd1);
    repeat (10) step();
    @(posedge c);
    #2 r = 1'b0;
    #1;
    check("t5_busy",  {63'b0, busy}, 64'd0);
    check("t5_ack",   64'(ack), 64'd0);
    check("t5_rsp",   64'(rsp_data), 64'd0);
    check("t5_wdata", 64'(sio_wdata), 64'd0);
    repeat (3) step();
    r = 1'b1;
    wait_wvalid("t5_reissue", 5);
    check("t5_wdata2", 64'(sio_wdata), 64'h5A_0BADCAFE);
    check("t5_noack",  64'(gq.size()), 64'd0);
    wait_ack("t5_ack0", 0, 40);
    req = 4'b0000;
    check("t5_lat", 64'(aq[0] - wq[wq.size()-1]), 64'd33);
    check("t5_rsp2", 64'(rsp_data), 64'h12345678);
    wait_idle("t5_idle", 10);
    check("consec_wv", 64'(n_consec), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
